// File: rtl/fetch_unit.sv
// Pipeline front end: owns the PC, issues in-order instruction-memory requests under a
// credit limit, and buffers returned words with their PC for the IF/ID register.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned           QDEPTH     = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [5:0]            stall_i,
  input  logic                  flush_jump_i,
  input  logic [ADDR_WIDTH-1:0] new_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o
);

  // Handshakes: a request transfers when imem_req_o && imem_gnt_i; responses arrive in
  // request order, one per imem_rvalid_i; an instruction transfers to IF/ID when
  // inst_valid_o && !stall_i[1], and the head is held stable otherwise.

  localparam int unsigned     PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned     CW   = $clog2(QDEPTH + 1);
  localparam logic [CW:0]     QMAX = (CW+1)'(QDEPTH);

  logic [ADDR_WIDTH-1:0]            pc_q;
  logic [ADDR_WIDTH-1:0]            tag_mem [QDEPTH];
  logic [PW-1:0]                    tag_wr_q, tag_rd_q;
  logic [CW-1:0]                    inflight_q, drop_cnt_q;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] out_mem [QDEPTH];
  logic [PW-1:0]                    out_wr_q, out_rd_q;
  logic [CW-1:0]                    out_cnt_q;
  logic [CW:0]                      occupancy;
  logic                             issue, rsp_keep, out_pop;
  logic                             unused_stall;

  assign unused_stall = ^stall_i[5:2];

  // Credit counts both outstanding (including to-be-dropped) requests and buffered words.
  assign occupancy  = {1'b0, inflight_q} + {1'b0, out_cnt_q};
  assign imem_req_o = rst_n_i && !flush_jump_i && !stall_i[0] && (occupancy < QMAX);
  assign imem_addr_o = pc_q;
  assign issue      = imem_req_o && imem_gnt_i;
  assign rsp_keep   = imem_rvalid_i && (drop_cnt_q == '0) && !flush_jump_i;

  assign inst_valid_o = (out_cnt_q != '0) && !flush_jump_i;
  assign out_pop      = inst_valid_o && !stall_i[1];
  assign {inst_pc_o, inst_o} = (out_cnt_q != '0) ? out_mem[out_rd_q]
                                                 : {{ADDR_WIDTH{1'b0}}, NOP_INST};

  always_ff @(posedge clk_i) begin
    if (issue)    tag_mem[tag_wr_q] <= pc_q;
    if (rsp_keep) out_mem[out_wr_q] <= {tag_mem[tag_rd_q], imem_rdata_i};
  end

  // PC and request side; tags are popped for every response, kept or dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q       <= RESET_PC;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (flush_jump_i) pc_q <= {new_pc_i[ADDR_WIDTH-1:2], 2'b00};
      else if (issue)   pc_q <= pc_q + ADDR_WIDTH'(4);
      if (issue)         tag_wr_q <= tag_wr_q + PW'(1);
      if (imem_rvalid_i) tag_rd_q <= tag_rd_q + PW'(1);
      case ({issue, imem_rvalid_i})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
      // Every request still outstanding after this cycle belongs to the old stream.
      if (flush_jump_i)
        drop_cnt_q <= inflight_q - CW'(imem_rvalid_i);
      else if (imem_rvalid_i && (drop_cnt_q != '0))
        drop_cnt_q <= drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else if (flush_jump_i) begin
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (rsp_keep) out_wr_q <= out_wr_q + PW'(1);
      if (out_pop)  out_rd_q <= out_rd_q + PW'(1);
      case ({rsp_keep, out_pop})
        2'b10:   out_cnt_q <= out_cnt_q + CW'(1);
        2'b01:   out_cnt_q <= out_cnt_q - CW'(1);
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency in-order memory model plus a stream-level
// reference (next PC, epoch-tagged outstanding requests, expected IF/ID queue).
module tb_fetch_unit;

  localparam int          QD     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(
    .ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC), .QDEPTH(QD), .NOP_INST(NOP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_jump_i(flush), .new_pc_i(new_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] model_pc = RST_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          gnt_pct = 100, lat_lo = 1, lat_hi = 1;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], 16'h0} ^ (a * 32'h0000_9E37) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: entered at posedge+1, drives inputs, checks outputs, advances the model.
  task automatic cycle(input logic fl, input logic [31:0] npc);
    int          occ;
    logic        exp_req, exp_valid, keep;
    logic [63:0] head;
    mreq_t       m;
    flush  = fl;
    new_pc = npc;
    gnt    = ($urandom_range(99) < gnt_pct);
    rvalid = 1'b0;
    rdata  = $urandom;
    if (rst_n && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      rvalid = 1'b1;
      rdata  = inst_of(mem_q[0].addr);
    end
    #3;
    occ       = mem_q.size() + exp_q.size();
    exp_req   = rst_n && !fl && !stall[0] && (occ < QD);
    exp_valid = rst_n && (exp_q.size() > 0) && !fl;
    head      = (exp_q.size() > 0) ? exp_q[0] : {32'h0, NOP};
    chk("imem_req", {63'h0, imem_req}, {63'h0, exp_req});
    chk("imem_addr", {32'h0, imem_addr}, {32'h0, model_pc});
    chk("inst_valid", {63'h0, inst_valid}, {63'h0, exp_valid});
    if (!fl) chk("inst_pc_inst", {inst_pc, inst}, head);
    if (rst_n) begin
      keep = 1'b0;
      if (rvalid) begin
        m    = mem_q.pop_front();
        keep = (m.epoch == epoch) && !fl;
      end
      if (fl) begin
        exp_q.delete();
        epoch++;
        model_pc = {npc[31:2], 2'b00};
      end else begin
        if (exp_valid && !stall[1]) void'(exp_q.pop_front());
        if (keep) exp_q.push_back({m.addr, inst_of(m.addr)});
        if (exp_req && gnt) begin
          m.addr  = model_pc;
          m.epoch = epoch;
          m.ready = cyc + $urandom_range(lat_hi, lat_lo);
          mem_q.push_back(m);
          model_pc = model_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n, input int fl_pct, input bit rnd_stall);
    logic fl;
    for (int i = 0; i < n; i++) begin
      if (rnd_stall)
        stall = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'd0;
      fl = ($urandom_range(99) < fl_pct);
      cycle(fl, $urandom);
    end
  endtask

  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req", {63'h0, imem_req}, 64'h0);
    chk("rst_addr", {32'h0, imem_addr}, {32'h0, RST_PC});
    chk("rst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_inst", {inst_pc, inst}, {32'h0, NOP});
    mem_q.delete();
    exp_q.delete();
    model_pc = RST_PC;
    epoch++;
    @(posedge clk);
    #1;
    cyc++;
    cycle(1'b0, 32'h0);
    cycle(1'b0, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    repeat (3) cycle(1'b0, 32'h0);
    rst_n = 1'b1;

    // continuous stream, always granted, 1-cycle latency
    run(12, 0, 1'b0);

    // hold PC and IF output while responses drain into the buffer
    stall = 6'b000111;
    repeat (5) cycle(1'b0, 32'h0);
    stall = '0;
    run(10, 0, 1'b0);

    // redirect with two requests in flight
    lat_lo = 3; lat_hi = 3;
    run(6, 0, 1'b0);
    cycle(1'b1, 32'h0000_0100);
    run(12, 0, 1'b0);

    // redirect while a response is arriving, then back-to-back redirects
    lat_lo = 1; lat_hi = 1;
    run(5, 0, 1'b0);
    cycle(1'b1, 32'h0000_0200);
    cycle(1'b1, 32'h0000_0300);
    run(8, 0, 1'b0);

    // misaligned target and PC wrap
    cycle(1'b1, 32'h0000_0103);
    run(6, 0, 1'b0);
    cycle(1'b1, 32'hFFFF_FFF4);
    run(8, 0, 1'b0);

    // random grants, latencies, stalls and redirects
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    run(400, 5, 1'b1);
    stall = '0;

    // asynchronous reset mid-stream
    gnt_pct = 100; lat_lo = 3; lat_hi = 3;
    run(6, 0, 1'b0);
    reset_mid();
    lat_lo = 1; lat_hi = 2;
    run(12, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
